// File: rtl/mbox_req_arb_if.sv
// mbox_req_arb_if: EBOX/MBOX request-response bundle for the request arbiter.
// master = arbiter side, slave = MBOX side.
interface mbox_req_arb_if #(
    parameter int ADRW  = 23,
    parameter int DATAW = 36
);
    logic             EBOX_REQ;
    logic [ADRW-1:0]  EBOX_VMA;
    logic             eboxRead;
    logic             eboxWrite;
    logic [DATAW-1:0] cacheDataWrite;
    logic             cshEBOXT0;
    logic             cshEBOXRetry;
    logic             mboxRespIn;
    logic [DATAW-1:0] cacheDataRead;

    modport master (
        output EBOX_REQ, EBOX_VMA, eboxRead, eboxWrite, cacheDataWrite,
        input  cshEBOXT0, cshEBOXRetry, mboxRespIn, cacheDataRead
    );

    modport slave (
        input  EBOX_REQ, EBOX_VMA, eboxRead, eboxWrite, cacheDataWrite,
        output cshEBOXT0, cshEBOXRetry, mboxRespIn, cacheDataRead
    );
endinterface

// File: rtl/mbox_req_arb.sv
// mbox_req_arb: N-channel EBOX->MBOX request arbiter with retry and abort.
// Define MBOX_ARB_RR_EN for round-robin; default is fixed priority (ch0 highest).
module mbox_req_arb #(
    parameter int NCHAN     = 4,
    parameter int ADRW      = 23,
    parameter int DATAW     = 36,
    parameter int RETRY_MAX = 7
) (
    input  logic                   clk,
    input  logic                   RESET_N,
    input  logic [NCHAN-1:0]       chReq,
    input  logic [NCHAN-1:0]       chWrite,
    input  logic [NCHAN*ADRW-1:0]  chVMA,
    input  logic [NCHAN*DATAW-1:0] chWData,
    output logic [NCHAN-1:0]       chGrant,
    output logic [NCHAN-1:0]       chDone,
    output logic [NCHAN-1:0]       chAbort,
    output logic [DATAW-1:0]       chRData,
    output logic                   arbBusy,
    mbox_req_arb_if.master         mbox
);
    localparam int IW = (NCHAN > 1) ? $clog2(NCHAN) : 1;
    localparam logic [NCHAN-1:0] LSB = NCHAN'(1);
    localparam logic [3:0] RMAX = 4'(RETRY_MAX);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, FIN} arbState_e;

    arbState_e        state, stateNext;
    logic [IW-1:0]    owner, ownerNext, winner;
    logic             isWrite, isWriteNext;
    logic [ADRW-1:0]  vma, vmaNext;
    logic [DATAW-1:0] wData, wDataNext;
    logic [DATAW-1:0] rData, rDataNext;
    logic [3:0]       retryCnt, retryNext, retryInc;
    logic             abortFlag, abortNext;
    logic             owned;
    logic             anyReq;
    logic             cancel;

    assign anyReq   = |chReq;
    assign retryInc = retryCnt + 4'd1;
    // T0 in the same cycle as a dropped request still counts as accepted.
    assign cancel   = (state == REQ) && !mbox.cshEBOXT0 && !chReq[owner];

`ifdef MBOX_ARB_RR_EN
    logic [IW-1:0] ptr;
    logic [IW-1:0] ownerInc;
    logic [IW:0]   cand;
    logic          found;

    assign ownerInc = (owner == IW'(NCHAN - 1)) ? '0 : owner + IW'(1);

    // Scan upward from the pointer, wrapping once.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int i = 0; i < NCHAN; i++) begin
            cand = {1'b0, ptr} + (IW + 1)'(i);
            if (cand >= (IW + 1)'(NCHAN))
                cand = cand - (IW + 1)'(NCHAN);
            if (!found && chReq[cand[IW-1:0]]) begin
                winner = cand[IW-1:0];
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N)
            ptr <= '0;
        else if (state == FIN || cancel)
            ptr <= ownerInc;
    end
`else
    always_comb begin
        winner = '0;
        for (int i = NCHAN - 1; i >= 0; i--)
            if (chReq[i]) winner = IW'(i);
    end
`endif

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= IDLE;
            owner     <= '0;
            isWrite   <= 1'b0;
            vma       <= '0;
            wData     <= '0;
            rData     <= '0;
            retryCnt  <= '0;
            abortFlag <= 1'b0;
        end else begin
            state     <= stateNext;
            owner     <= ownerNext;
            isWrite   <= isWriteNext;
            vma       <= vmaNext;
            wData     <= wDataNext;
            rData     <= rDataNext;
            retryCnt  <= retryNext;
            abortFlag <= abortNext;
        end
    end

    always_comb begin
        stateNext   = state;
        ownerNext   = owner;
        isWriteNext = isWrite;
        vmaNext     = vma;
        wDataNext   = wData;
        rDataNext   = rData;
        retryNext   = retryCnt;
        abortNext   = abortFlag;
        unique case (state)
            IDLE: if (anyReq) begin
                stateNext   = REQ;
                ownerNext   = winner;
                isWriteNext = chWrite[winner];
                vmaNext     = chVMA[winner*ADRW +: ADRW];
                wDataNext   = chWData[winner*DATAW +: DATAW];
            end
            REQ: begin
                if (mbox.cshEBOXT0)
                    stateNext = WAIT;
                else if (cancel)
                    stateNext = IDLE;
            end
            WAIT: begin
                if (mbox.mboxRespIn) begin
                    stateNext = FIN;
                    if (!isWrite)
                        rDataNext = mbox.cacheDataRead;
                end else if (mbox.cshEBOXRetry) begin
                    retryNext = retryInc;
                    if (retryInc == RMAX) begin
                        stateNext = FIN;
                        abortNext = 1'b1;
                    end else begin
                        stateNext = REQ;
                    end
                end
            end
            FIN: begin
                stateNext = IDLE;
                retryNext = '0;
                abortNext = 1'b0;
            end
            default: stateNext = IDLE;
        endcase
    end

    // Grant drops on entry to FIN so grant and done never overlap.
    assign owned   = (state == REQ) || (state == WAIT);
    assign chGrant = owned ? (LSB << owner) : '0;
    assign chDone  = (state == FIN && !abortFlag) ? (LSB << owner) : '0;
    assign chAbort = (state == FIN && abortFlag) ? (LSB << owner) : '0;
    assign chRData = rData;
    assign arbBusy = (state != IDLE);

    assign mbox.EBOX_REQ       = (state == REQ);
    assign mbox.EBOX_VMA       = vma;
    assign mbox.eboxRead       = owned && !isWrite;
    assign mbox.eboxWrite      = owned && isWrite;
    assign mbox.cacheDataWrite = wData;
endmodule
